inst_fetch: RTL

- Program-counter and fetch-sequencing stage directly upstream of the instruction ROM in the single-cycle MIPS core.
- Drives the ROM byte address and consumes the ROM's registered, byte-swapped 32-bit instruction, which arrives one cycle after the address is sampled.
- Pairs each returned instruction with its PC, holds it stable under downstream stall, and squashes in-flight fetches on branch/jump redirect.

---
 rtl/inst_fetch.sv | 62 ++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Program counter and fetch sequencing in front of the registered instruction ROM.
// Tags each returned ROM word with its PC, holds it under stall, squashes on redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4,
    output logic        inst_valid,
    output logic        misaligned
);

    logic [31:0] fetch_pc;
    logic [31:0] resp_pc;
    logic        resp_valid;
    logic [31:0] hold_data;
    logic        hold_valid;
    logic        advance;

    // A bubble never blocks fetch, so stall only matters while a word is presented.
    assign advance = !stall || !resp_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            resp_pc    <= 32'd0;
            resp_valid <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= 32'd0;
            misaligned <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc   <= {redirect_target[31:2], 2'b00};
            resp_valid <= 1'b0;
            hold_valid <= 1'b0;
            misaligned <= misaligned | (redirect_target[1:0] != 2'b00);
        end else if (advance) begin
            resp_pc    <= fetch_pc;
            resp_valid <= 1'b1;
            fetch_pc   <= fetch_pc + PC_INC;
            hold_valid <= 1'b0;
        end else if (!hold_valid) begin
            // The ROM re-reads fetch_pc at this edge, so capture the presented word first.
            hold_data  <= rom_data;
            hold_valid <= 1'b1;
        end
    end

    assign rom_addr      = fetch_pc;
    assign inst_out      = hold_valid ? hold_data : rom_data;
    assign inst_pc       = resp_pc;
    assign inst_pc_plus4 = resp_pc + PC_INC;
    assign inst_valid    = resp_valid;

endmodule
